// File: rtl/analog_update_arbiter.sv
// Round-robin arbiter that serialises per-requester update pulses onto one shared
// upd_req/upd_ack analog update channel. Optional ack watchdog: define ARB_TIMEOUT_EN.
module analog_update_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] done,
  output logic             upd_req,
  output logic [N_REQ-1:0] upd_sel,
  input  logic             upd_ack,
  output logic             busy,
  output logic             timeout_err,
  output logic [1:0]       o_dbg_state
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int IW = PW + 1;

  // Channel handshake: upd_req is a single-cycle pulse per grant, raised in ISSUE;
  // upd_ack is honoured only in ISSUE and WAIT_ACK and ignored in every other state.
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_WAIT_ACK = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t           r_state;
  logic [N_REQ-1:0] r_pending;
  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    r_sel;
  logic [N_REQ-1:0] r_done;
  logic [N_REQ-1:0] r_upd_sel;
  logic             r_upd_req;
  logic             r_busy;

  logic             w_found;
  logic [PW-1:0]    w_grant;
  logic [IW-1:0]    w_idx;
  logic [N_REQ-1:0] w_sel_onehot;
  logic [N_REQ-1:0] w_clr;
  logic [N_REQ-1:0] w_pending_next;
  logic [PW-1:0]    w_ptr_next;
  logic             w_expired;

  function automatic logic [N_REQ-1:0] f_onehot(input logic [PW-1:0] i);
    logic [N_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // First pending bit at or above r_ptr, wrapping modulo N_REQ.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = {1'b0, r_ptr} + IW'(k);
      if (w_idx >= IW'(N_REQ)) begin
        w_idx = w_idx - IW'(N_REQ);
      end
      if (!w_found && r_pending[w_idx[PW-1:0]]) begin
        w_found = 1'b1;
        w_grant = w_idx[PW-1:0];
      end
    end
  end

  assign w_sel_onehot   = f_onehot(r_sel);
  assign w_clr          = (r_state == S_DONE) ? w_sel_onehot : '0;
  // A request arriving on the clearing edge survives, so it is served again.
  assign w_pending_next = (r_pending & ~w_clr) | req;
  assign w_ptr_next     = (r_sel == PW'(N_REQ - 1)) ? '0 : r_sel + 1'b1;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT) > 8) ? $clog2(TIMEOUT) : 8;

  logic [CW-1:0] r_wait_cnt;
  logic          r_timeout_err;

  assign w_expired = (r_wait_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state == S_ISSUE) begin
        r_wait_cnt <= '0;
      end else if (r_state == S_WAIT_ACK && !upd_ack && !w_expired) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      if (r_state == S_WAIT_ACK && !upd_ack && w_expired) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign timeout_err = r_timeout_err;
`else
  // Without the watchdog WAIT_ACK never expires; TIMEOUT has no effect.
  assign w_expired   = (TIMEOUT < 0);
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state   <= S_IDLE;
      r_pending <= '0;
      r_ptr     <= '0;
      r_sel     <= '0;
      r_done    <= '0;
      r_upd_sel <= '0;
      r_upd_req <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_pending <= w_pending_next;
      r_done    <= '0;
      r_upd_req <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state   <= S_ISSUE;
            r_sel     <= w_grant;
            r_upd_sel <= f_onehot(w_grant);
            r_upd_req <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (upd_ack) begin
            r_state <= S_DONE;
            r_done  <= w_sel_onehot;
          end else begin
            r_state <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          if (upd_ack || w_expired) begin
            r_state <= S_DONE;
            r_done  <= w_sel_onehot;
          end
        end
        S_DONE: begin
          r_state   <= S_IDLE;
          r_ptr     <= w_ptr_next;
          r_upd_sel <= '0;
          r_busy    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign done        = r_done;
  assign upd_req     = r_upd_req;
  assign upd_sel     = r_upd_sel;
  assign busy        = r_busy;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_analog_update_arbiter.sv
// Directed bench for analog_update_arbiter: per-cycle grant-phase model, grant-order
// scoreboard and hand-computed latency/order expectations.
`timescale 1ns/1ps
module tb_analog_update_arbiter;

  localparam int N  = 4;
  localparam int TO = 8;

  logic         clk     = 1'b0;
  logic         rstb    = 1'b0;
  logic [N-1:0] req     = '0;
  logic         upd_ack = 1'b0;
  logic [N-1:0] done;
  logic [N-1:0] upd_sel;
  logic         upd_req;
  logic         busy;
  logic         timeout_err;
  logic [1:0]   dbg_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ack_mode = 0;
  logic sb_en = 1'b0;
  logic [N-1:0] exp_q[$];
  logic [N-1:0] sb_exp;
  int cnt_upd = 0;
  int cnt_done2 = 0;
  int cnt_done_any = 0;
  int n;
  int k;
  int t_done[5];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  analog_update_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rstb(rstb), .req(req), .done(done), .upd_req(upd_req),
    .upd_sel(upd_sel), .upd_ack(upd_ack), .busy(busy),
    .timeout_err(timeout_err), .o_dbg_state(dbg_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // m_stage: 0 no grant, 1 request cycle, 2 awaiting ack, 3 completion cycle.
  int           m_stage, m_srv, m_ptr, m_wcnt;
  logic [N-1:0] m_pend, m_keep, e_sel;
  logic         m_terr;

  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      m_stage = 0; m_srv = 0; m_ptr = 0; m_wcnt = 0; m_pend = '0; m_terr = 1'b0;
    end else begin
      m_keep = m_pend;
      if (m_stage == 3) m_keep[m_srv] = 1'b0;
      case (m_stage)
        0: begin
          for (int j = 0; j < N; j++) begin
            if (m_stage == 0 && m_pend[(m_ptr + j) % N]) begin
              m_srv   = (m_ptr + j) % N;
              m_stage = 1;
            end
          end
        end
        1: begin
          m_stage = upd_ack ? 3 : 2;
          m_wcnt  = 0;
        end
        2: begin
          if (upd_ack) m_stage = 3;
`ifdef ARB_TIMEOUT_EN
          else if (m_wcnt == TO - 1) begin
            m_stage = 3;
            m_terr  = 1'b1;
          end else m_wcnt++;
`endif
        end
        default: begin
          m_stage = 0;
          m_ptr   = (m_srv + 1) % N;
        end
      endcase
      m_pend = m_keep | req;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rstb) begin
      e_sel = '0;
      if (m_stage != 0) e_sel[m_srv] = 1'b1;
      chk("upd_req", upd_req, m_stage == 1);
      chk("upd_sel", upd_sel, e_sel);
      chk("done", done, (m_stage == 3) ? e_sel : '0);
      chk("busy", busy, m_stage != 0);
      chk("timeout_err", timeout_err, m_terr);
    end
  end

  // ---------------- scoreboard / counters ----------------
  always @(negedge clk) begin
    if (rstb) begin
      if (upd_req) cnt_upd++;
      if (done[2]) cnt_done2++;
      if (done != 0) cnt_done_any++;
      if (sb_en && done != 0) begin
        if (exp_q.size() == 0) chk("sb_extra_done", done, 0);
        else begin
          sb_exp = exp_q.pop_front();
          chk("sb_done_order", done, sb_exp);
        end
      end
    end
  end

  // Auto-acknowledge in the request cycle when ack_mode == 1.
  always @(negedge clk) if (ack_mode == 1) upd_ack = upd_req;

  // ---------------- driver tasks ----------------
  task automatic pulse_req(input logic [N-1:0] m);
    @(negedge clk); req = m;
    @(negedge clk); req = '0;
  endtask

  task automatic wait_upd_req(input string name, output int cnt);
    cnt = 0;
    for (int i = 1; i <= 40; i++) if (cnt == 0) begin
      @(negedge clk);
      if (upd_req) cnt = i;
    end
    chk(name, cnt != 0, 1);
  endtask

  task automatic wait_dones(input string name, input int want);
    int got;
    got = 0;
    for (int i = 0; i < 80; i++) if (got < want) begin
      @(negedge clk);
      if (done != 0) got++;
    end
    chk(name, got, want);
  endtask

  task automatic wait_idle(input string name);
    int ok;
    ok = 0;
    for (int i = 0; i < 200; i++) if (ok == 0) begin
      @(negedge clk);
      if (!busy && m_pend == 0 && m_stage == 0) ok = 1;
    end
    chk(name, ok, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_done", done, 0);
    chk("rst_upd_req", upd_req, 0);
    chk("rst_upd_sel", upd_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_state", dbg_state, 0);
    rstb = 1'b1;

    // Round-robin with all requesters held and ack in the request cycle.
    ack_mode = 1; sb_en = 1'b1;
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000); exp_q.push_back(4'b0001);
    for (int i = 0; i < 5; i++) t_done[i] = 0;
    @(negedge clk); req = 4'b1111;
    k = 0;
    for (int i = 0; i < 60; i++) if (k < 5) begin
      @(negedge clk);
      if (done != 0) begin t_done[k] = cyc; k++; end
    end
    chk("rr_five_grants", k, 5);
    #1; sb_en = 1'b0; req = '0;
    chk("rr_queue_empty", exp_q.size(), 0);
    for (int i = 1; i < 5; i++) chk("rr_spacing", t_done[i] - t_done[i-1], 3);
    wait_idle("rr_drain");
    ack_mode = 0;

    // Single request, ack three cycles after upd_req.
    pulse_req(4'b0010);
    wait_upd_req("single_issue_seen", n);
    chk("single_issue_latency", n, 1);
    chk("single_sel", upd_sel, 4'b0010);
    @(negedge clk); @(negedge clk);
    @(negedge clk); upd_ack = 1'b1;
    @(negedge clk); upd_ack = 1'b0;
    chk("single_done", done, 4'b0010);
    @(negedge clk);
    chk("single_done_once", done, 0);
    chk("single_busy_low", busy, 0);

    // Re-request raised in the final WAIT_ACK cycle and held over the clearing edge.
    cnt_upd = 0; cnt_done2 = 0;
    pulse_req(4'b0100);
    wait_upd_req("rereq_issue_seen", n);
    @(negedge clk);
    chk("rereq_waiting", dbg_state, 2);
    @(negedge clk); req = 4'b0100; upd_ack = 1'b1;
    @(negedge clk); upd_ack = 1'b0;
    chk("rereq_first_done", done, 4'b0100);
    ack_mode = 1;
    @(negedge clk); req = '0;
    wait_idle("rereq_drain");
    chk("rereq_upd_count", cnt_upd, 2);
    chk("rereq_done_count", cnt_done2, 2);

    // Pointer sits at 3 after serving requester 2.
    sb_en = 1'b1;
    exp_q.push_back(4'b1000); exp_q.push_back(4'b0001);
    pulse_req(4'b1001);
    wait_dones("simul_two_grants", 2);
    #1; sb_en = 1'b0;
    chk("simul_queue_empty", exp_q.size(), 0);
    wait_idle("simul_drain");

    // Reset while waiting for ack.
    ack_mode = 0;
    pulse_req(4'b0010);
    wait_upd_req("rstmid_issue_seen", n);
    @(negedge clk);
    chk("rstmid_busy_before", busy, 1);
    cnt_done_any = 0;
    #2 rstb = 1'b0;
    #1;
    chk("rstmid_done", done, 0);
    chk("rstmid_upd_req", upd_req, 0);
    chk("rstmid_upd_sel", upd_sel, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_terr", timeout_err, 0);
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    repeat (3) @(negedge clk);
    chk("rstmid_no_done", cnt_done_any, 0);
    chk("rstmid_idle", busy, 0);
    ack_mode = 1; sb_en = 1'b1;
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100); exp_q.push_back(4'b1000);
    pulse_req(4'b1111);
    wait_dones("rstmid_four_grants", 4);
    #1; sb_en = 1'b0;
    chk("rstmid_queue_empty", exp_q.size(), 0);
    wait_idle("rstmid_drain");

`ifdef ARB_TIMEOUT_EN
    // No ack: watchdog completes the grant and latches the error.
    ack_mode = 0;
    pulse_req(4'b0001);
    wait_upd_req("to_issue_seen", n);
    n = 0;
    for (int i = 1; i <= 30; i++) if (n == 0) begin
      @(negedge clk);
      if (done != 0) n = i;
    end
    chk("to_done_latency", n, 9);
    chk("to_done_sel", done, 4'b0001);
    @(negedge clk);
    chk("to_err_set", timeout_err, 1);
    upd_ack = 1'b1;
    @(negedge clk); upd_ack = 1'b0;
    chk("to_late_ack_ignored", busy, 0);
    ack_mode = 1; sb_en = 1'b1;
    exp_q.push_back(4'b0010);
    pulse_req(4'b0010);
    wait_dones("to_next_grant", 1);
    #1; sb_en = 1'b0;
    wait_idle("to_drain");
    chk("to_err_sticky", timeout_err, 1);
`endif

    ack_mode = 0;
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
